crc16_tx: RTL and testbench
===========================

Name: crc16_tx

Overview:
- Transmit-side CRC-16 (EPC Gen2, poly x^16+x^12+x^5+1, preset 0xFFFF) for tag replies.
- Passes reply data bits through to the modulator while accumulating CRC; on request, appends the 16-bit ones'-complement CRC serially, MSB first.
- Sits between the reply-bit sequencer and the backscatter encoder. Complements the receive-side CRC16 check: a reply framed by this block leaves residue 0x1D0F in that check.

Parameters:
- PRESET, 16'hFFFF, CRC register value after reset, after clear, and at end of frame.
- INVERT, 1, 1 = transmit ones' complement of CRC (Gen2); 0 = transmit raw CRC (debug only).

Ports:
- crcinclk  in  1  bit clock, one reply bit per rising edge
- reset  in  1  asynchronous, active-high
- crcclear  in  1  synchronous abort: return to IDLE, crc=PRESET
- databit  in  1  reply data bit
- dataen  in  1  databit valid this edge; accumulate and transmit
- crcsend  in  1  request to append CRC; sampled in IDLE only
- txbit  out  1  registered serial output (data or CRC bit)
- txvalid  out  1  txbit holds a valid bit this cycle
- crcbusy  out  1  high while CRC bits are being shifted out
- crcdone  out  1  one-cycle pulse coincident with last CRC bit on txbit
- crc  out  16  current CRC register (parallel, for debug and self-check)

Behaviour:
- Reset is asynchronous and active-high; clock is crcinclk. On reset: crc=PRESET, state=IDLE, cnt=0, txbit=0, txvalid=0, crcbusy=0, crcdone=0.
- Update rule (fb = databit ^ crc[15]):
  - crc[0] <= fb
  - crc[5] <= crc[4]^fb
  - crc[12] <= crc[11]^fb
  - all other bits shift up by one: crc[i] <= crc[i-1].
- States: IDLE, SEND.
- IDLE:
  - dataen=1, crcsend=0: apply update; txbit<=databit; txvalid<=1. One-cycle latency from databit to txbit.
  - crcsend=1: takes priority over dataen (that databit is dropped, not accumulated). Go to SEND; cnt<=0. txbit<=crc[15]^INVERT; txvalid<=1; crcbusy<=1. crc<={crc[14:0],1'b1}.
  - neither: txvalid<=0; txbit<=0; crc held.
- SEND:
  - Each edge: txbit<=crc[15]^INVERT; crc<={crc[14:0],1'b1}; cnt<=cnt+1.
  - dataen and crcsend are ignored.
  - When cnt reaches 15 (16th bit driven onto txbit), crcdone<=1 for that cycle. Next edge goes to IDLE with crcbusy<=0, crcdone<=0; txvalid follows the IDLE rules.
  - Shifting in ones leaves crc=0xFFFF (PRESET) after the 16th shift, so the block is ready for the next frame with no extra cycle.
- Back-to-back: a new frame may start with dataen on the edge immediately after crcdone.
- crcclear has priority over everything except reset. On the next edge: IDLE, crc=PRESET, cnt=0, txvalid=0, crcbusy=0, crcdone=0. This applies mid-data and mid-SEND (partial CRC is truncated).
- Reset mid-SEND: immediate return to reset values; no crcdone.
- Empty frame (crcsend with no prior data): transmits ~0xFFFF = 16 zeros.
- cnt is 4 bits and never wraps; it is reset on SEND entry.

Test Plan:
- Reset, then crcsend pulse with no data -> txbit=0 for 16 cycles, txvalid=1, crcbusy=1; crcdone on 16th; crc=0xFFFF afterwards.
- Single data bit 1, then crcsend -> crc=0xFFFE after data; CRC bits 0x0001 (15 zeros, then 1). Single bit 0 -> crc=0xEFDF; sent 0x1020.
- ASCII "123456789" (72 bits, MSB first per byte), then crcsend -> txbit passes data with 1-cycle latency; CRC bits = 0xD64E; residue in receive check after all 88 bits = 0x1D0F.
- Two frames back-to-back ("12", then "123456789") with dataen on the edge after crcdone -> second CRC = 0xD64E, proving automatic preset.
- crcclear asserted at CRC bit 7 -> txvalid=0 next cycle, no crcdone, crc=0xFFFF; following frame correct.
- dataen and crcsend together in IDLE -> databit dropped (crc unchanged before shift); dataen during SEND ignored; async reset mid-SEND clears all outputs without waiting for a clock edge.

Source files
------------

// File: rtl/crc16_tx.sv
// Transmit-side EPC Gen2 CRC-16 (x^16+x^12+x^5+1): passes reply bits through while
// accumulating the CRC, then shifts the complemented CRC out MSB first on request.
//
// state   | meaning
// --------+---------------------------------------------------------------
// ST_IDLE | pass data bits through and accumulate CRC, or wait
// ST_SEND | shift the 16 CRC bits onto txbit, MSB first
module crc16_tx #(
  parameter logic [15:0] PRESET = 16'hFFFF,
  parameter logic        INVERT = 1'b1
) (
  input  logic        crcinclk,
  input  logic        reset,
  input  logic        crcclear,
  input  logic        databit,
  input  logic        dataen,
  input  logic        crcsend,
  output logic        txbit,
  output logic        txvalid,
  output logic        crcbusy,
  output logic        crcdone,
  output logic [15:0] crc
);

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_SEND = 1'b1;

  logic [0:0]  state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [15:0] crc_q, crc_d;
  logic        txbit_q, txbit_d;
  logic        txvalid_q, txvalid_d;
  logic        crcbusy_q, crcbusy_d;
  logic        crcdone_q, crcdone_d;

  logic        fb;
  logic [15:0] crc_upd;
  logic [15:0] crc_shift;

  always_comb begin
    fb          = databit ^ crc_q[15];
    crc_upd     = {crc_q[14:0], fb};
    crc_upd[5]  = crc_q[4] ^ fb;
    crc_upd[12] = crc_q[11] ^ fb;
    // Shifting ones in leaves the register at all-ones after the 16th bit.
    crc_shift   = {crc_q[14:0], 1'b1};
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    crc_d     = crc_q;
    txbit_d   = txbit_q;
    txvalid_d = txvalid_q;
    crcbusy_d = crcbusy_q;
    crcdone_d = 1'b0;
    if (crcclear) begin
      state_d   = ST_IDLE;
      cnt_d     = 4'd0;
      crc_d     = PRESET;
      txbit_d   = 1'b0;
      txvalid_d = 1'b0;
      crcbusy_d = 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          crcbusy_d = 1'b0;
          if (crcsend) begin
            state_d   = ST_SEND;
            cnt_d     = 4'd0;
            txbit_d   = crc_q[15] ^ INVERT;
            txvalid_d = 1'b1;
            crcbusy_d = 1'b1;
            crc_d     = crc_shift;
          end else if (dataen) begin
            crc_d     = crc_upd;
            txbit_d   = databit;
            txvalid_d = 1'b1;
          end else begin
            txbit_d   = 1'b0;
            txvalid_d = 1'b0;
          end
        end
        ST_SEND: begin
          txbit_d   = crc_q[15] ^ INVERT;
          txvalid_d = 1'b1;
          crcbusy_d = 1'b1;
          crc_d     = crc_shift;
          cnt_d     = cnt_q + 4'd1;
          // Leave SEND as the last bit is driven so the crcdone cycle can start a new frame.
          if (cnt_q == 4'd14) begin
            crcdone_d = 1'b1;
            state_d   = ST_IDLE;
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge crcinclk or posedge reset) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      cnt_q     <= 4'd0;
      crc_q     <= PRESET;
      txbit_q   <= 1'b0;
      txvalid_q <= 1'b0;
      crcbusy_q <= 1'b0;
      crcdone_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      crc_q     <= crc_d;
      txbit_q   <= txbit_d;
      txvalid_q <= txvalid_d;
      crcbusy_q <= crcbusy_d;
      crcdone_q <= crcdone_d;
    end
  end

  assign txbit   = txbit_q;
  assign txvalid = txvalid_q;
  assign crcbusy = crcbusy_q;
  assign crcdone = crcdone_q;
  assign crc     = crc_q;

endmodule

// File: tb/tb_crc16_tx.sv
// Bench for crc16_tx: directed Gen2 vectors plus random frames checked against a
// bitwise polynomial CRC model and the receive-side 0x1D0F residue.
module tb_crc16_tx;
  logic        crcinclk = 1'b0;
  logic        reset, crcclear, databit, dataen, crcsend;
  logic        txbit, txvalid, crcbusy, crcdone;
  logic [15:0] crc;

  int          n_tests = 0;
  int          n_fail  = 0;
  logic [15:0] m_crc;
  logic        fbits[$];
  logic [7:0]  msg[9];
  logic [15:0] sent;

  crc16_tx dut (
    .crcinclk(crcinclk), .reset(reset), .crcclear(crcclear), .databit(databit),
    .dataen(dataen), .crcsend(crcsend), .txbit(txbit), .txvalid(txvalid),
    .crcbusy(crcbusy), .crcdone(crcdone), .crc(crc)
  );

  always #5 crcinclk = ~crcinclk;

  function automatic logic [15:0] crc_step(input logic [15:0] c, input logic b);
    if (c[15] ^ b) return (c << 1) ^ 16'h1021;
    return c << 1;
  endfunction

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic cyc;
    @(posedge crcinclk);
    #1;
  endtask

  task automatic data_bit(input logic b);
    databit = b; dataen = 1'b1; crcsend = 1'b0; crcclear = 1'b0;
    cyc;
    m_crc = crc_step(m_crc, b);
    fbits.push_back(b);
    chk("data_txbit", txbit, b);
    chk("data_txvalid", txvalid, 1'b1);
    chk("data_busy", crcbusy, 1'b0);
    chk("data_crc", crc, m_crc);
  endtask

  task automatic idle_cyc;
    dataen = 1'b0; crcsend = 1'b0; databit = 1'($urandom);
    cyc;
    chk("idle_txvalid", txvalid, 1'b0);
    chk("idle_txbit", txbit, 1'b0);
    chk("idle_crc", crc, m_crc);
  endtask

  task automatic send_msg(input int n);
    for (int k = 0; k < n; k++)
      for (int b = 7; b >= 0; b--) data_bit(msg[k][b]);
  endtask

  // clear_at >= 0 aborts with crcclear after CRC bit clear_at+1 is on txbit.
  task automatic send_crc(input logic with_data, output logic [15:0] s, input int clear_at);
    logic [15:0] exp, sh;
    exp = ~m_crc;
    sh  = m_crc;
    s   = 16'h0;
    crcsend = 1'b1; dataen = with_data; databit = 1'($urandom);
    cyc;
    for (int i = 0; i < 16; i++) begin
      sh = {sh[14:0], 1'b1};
      chk("crc_txbit", txbit, exp[15-i]);
      s[15-i] = txbit;
      chk("crc_txvalid", txvalid, 1'b1);
      chk("crc_busy", crcbusy, 1'b1);
      chk("crc_done", crcdone, (i == 15));
      chk("crc_shift", crc, sh);
      if (i == 15) break;
      if (i == clear_at) begin
        crcclear = 1'b1; dataen = 1'b0; crcsend = 1'b0;
        cyc;
        crcclear = 1'b0;
        chk("clr_txvalid", txvalid, 1'b0);
        chk("clr_busy", crcbusy, 1'b0);
        chk("clr_done", crcdone, 1'b0);
        chk("clr_crc", crc, 16'hFFFF);
        m_crc = 16'hFFFF;
        fbits.delete();
        return;
      end
      crcsend = 1'($urandom); dataen = 1'($urandom); databit = 1'($urandom);
      cyc;
    end
    crcsend = 1'b0; dataen = 1'b0;
    chk("end_crc", crc, 16'hFFFF);
    m_crc = 16'hFFFF;
  endtask

  task automatic residue(input logic [15:0] s);
    logic [15:0] r;
    r = 16'hFFFF;
    foreach (fbits[k]) r = crc_step(r, fbits[k]);
    for (int i = 15; i >= 0; i--) r = crc_step(r, s[i]);
    chk("residue", r, 16'h1D0F);
    fbits.delete();
  endtask

  initial begin
    msg = '{8'h31, 8'h32, 8'h33, 8'h34, 8'h35, 8'h36, 8'h37, 8'h38, 8'h39};
    m_crc = 16'hFFFF;
    crcclear = 0; databit = 0; dataen = 0; crcsend = 0;
    reset = 1'b0;
    #2 reset = 1'b1;
    #10;
    chk("rst_crc", crc, 16'hFFFF);
    chk("rst_txvalid", txvalid, 1'b0);
    chk("rst_txbit", txbit, 1'b0);
    chk("rst_busy", crcbusy, 1'b0);
    chk("rst_done", crcdone, 1'b0);
    reset = 1'b0;

    idle_cyc;
    send_crc(1'b0, sent, -1);
    chk("empty_frame", sent, 16'h0000);
    residue(sent);
    idle_cyc;

    data_bit(1'b1);
    chk("one_crc", crc, 16'hFFFE);
    send_crc(1'b0, sent, -1);
    chk("one_sent", sent, 16'h0001);
    residue(sent);
    idle_cyc;
    data_bit(1'b0);
    chk("zero_crc", crc, 16'hEFDF);
    send_crc(1'b0, sent, -1);
    chk("zero_sent", sent, 16'h1020);
    residue(sent);
    idle_cyc;

    send_msg(9);
    send_crc(1'b0, sent, -1);
    chk("ascii_sent", sent, 16'hD64E);
    residue(sent);
    idle_cyc;

    send_msg(2);
    send_crc(1'b0, sent, -1);
    residue(sent);
    send_msg(9);
    send_crc(1'b0, sent, -1);
    chk("b2b_sent", sent, 16'hD64E);
    residue(sent);

    send_msg(3);
    send_crc(1'b0, sent, 6);
    idle_cyc;
    send_msg(9);
    send_crc(1'b0, sent, -1);
    chk("post_clr_sent", sent, 16'hD64E);
    residue(sent);

    send_msg(4);
    send_crc(1'b1, sent, -1);
    residue(sent);
    idle_cyc;

    send_msg(2);
    crcsend = 1'b1; dataen = 1'b0;
    cyc;
    crcsend = 1'b0; dataen = 1'b1;
    cyc;
    cyc;
    #2 reset = 1'b1;
    #1;
    chk("arst_txvalid", txvalid, 1'b0);
    chk("arst_busy", crcbusy, 1'b0);
    chk("arst_done", crcdone, 1'b0);
    chk("arst_txbit", txbit, 1'b0);
    chk("arst_crc", crc, 16'hFFFF);
    #1 reset = 1'b0;
    dataen = 1'b0;
    m_crc = 16'hFFFF;
    fbits.delete();
    idle_cyc;

    for (int f = 0; f < 25; f++) begin
      int len, gap;
      len = int'($urandom_range(0, 40));
      for (int k = 0; k < len; k++) data_bit(1'($urandom));
      if ($urandom_range(0, 4) == 0) begin
        send_crc(1'($urandom), sent, int'($urandom_range(0, 14)));
      end else begin
        send_crc(1'($urandom), sent, -1);
        residue(sent);
      end
      gap = int'($urandom_range(0, 2));
      for (int k = 0; k < gap; k++) idle_cyc;
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
